unary_decoder: RTL and testbench

Converts a unary (stochastic) bitstream, such as the product stream of the unary multiplier, back to a binary value. It counts ones over a fixed window of 2^BITWIDTH enabled cycles and presents the count as a BITWIDTH-bit result on a valid/ready output register. It sits at the output end of the unary datapath, after uMUL-style blocks and their sobol-driven encoders. Windows run back-to-back continuously.

---
 rtl/unary_decoder.sv | 121 ++++++++++++
 tb/tb_unary_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/unary_decoder.sv
// Unary bitstream decoder: counts ones over back-to-back windows of
// 2^BITWIDTH enabled cycles and offers each window's count on a
// valid/ready output register, saturating the all-ones window to the
// largest representable value and flagging it on oSat.
module unary_decoder #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iBit,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oBin,
  output logic                oValid,
  output logic                oSat,
  output logic                oDrop
);

  // Window position and running count; the count needs one extra bit so a
  // window of all ones (2^BITWIDTH) is representable before saturation.
  logic [BITWIDTH-1:0] wcntReg, wcntNext;
  logic [BITWIDTH:0]   accReg, accNext;

  // Output register state.
  logic [BITWIDTH-1:0] binReg, binNext;
  logic                validReg, validNext;
  logic                satReg, satNext;
  logic                dropReg, dropNext;

  // The window phase is derived from the counter: the last slot is when
  // every counter bit is set.
  logic isLast;
  assign isLast = (wcntReg == {BITWIDTH{1'b1}});

  // Count including the bit presented in the final slot of the window.
  logic [BITWIDTH:0] result;
  assign result = accReg + {{BITWIDTH{1'b0}}, iBit};

  // A window completes on an enabled final slot unless a clear cancels it.
  logic complete;
  assign complete = iEn && isLast && !iClr;

  // Saturation: the top result bit only ever sets alone (exactly 2^BITWIDTH),
  // so OR-ing it into every lower bit yields 2^BITWIDTH-1 in that case.
  logic [BITWIDTH-1:0] satBin;
  genvar gi;
  generate
    for (gi = 0; gi < BITWIDTH; gi++) begin : gSat
      assign satBin[gi] = result[gi] | result[BITWIDTH];
    end
  endgenerate

  // Next-state: window advance, result hand-off and drop tracking.
  always_comb begin
    wcntNext  = wcntReg;
    accNext   = accReg;
    binNext   = binReg;
    validNext = validReg;
    satNext   = satReg;
    dropNext  = dropReg;

    if (iClr) begin
      // Clear discards the partial window and any pending result, but the
      // last presented value stays visible on oBin/oSat.
      wcntNext  = '0;
      accNext   = '0;
      validNext = 1'b0;
      dropNext  = 1'b0;
    end else begin
      if (iEn) begin
        if (isLast) begin
          wcntNext = '0;
          accNext  = '0;
        end else begin
          wcntNext = wcntReg + {{(BITWIDTH-1){1'b0}}, 1'b1};
          accNext  = result;
        end
      end

      if (complete) begin
        if (!validReg || iReady) begin
          // Output is free, or being consumed on this very edge.
          binNext   = satBin;
          satNext   = result[BITWIDTH];
          validNext = 1'b1;
        end else begin
          // Consumer still holds the previous result: discard the new one.
          dropNext = 1'b1;
        end
      end else if (validReg && iReady) begin
        validNext = 1'b0;
      end
    end
  end

  // State registers with synchronous reset dominating every other input.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wcntReg  <= '0;
      accReg   <= '0;
      binReg   <= '0;
      validReg <= 1'b0;
      satReg   <= 1'b0;
      dropReg  <= 1'b0;
    end else begin
      wcntReg  <= wcntNext;
      accReg   <= accNext;
      binReg   <= binNext;
      validReg <= validNext;
      satReg   <= satNext;
      dropReg  <= dropNext;
    end
  end

  assign oBin   = binReg;
  assign oValid = validReg;
  assign oSat   = satReg;
  assign oDrop  = dropReg;

endmodule

// File: tb/tb_unary_decoder.sv
// Testbench for unary_decoder: directed windows, a scoreboard queue of
// expected results and a monitor that checks every accepted transfer.
module tb_unary_decoder;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iEn = 1'b0;
  logic       iClr = 1'b0;
  logic       iBit = 1'b0;
  logic       iReady = 1'b0;
  logic [7:0] oBin;
  logic       oValid;
  logic       oSat;
  logic       oDrop;

  unary_decoder #(.BITWIDTH(8)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (iEn),
    .iClr  (iClr),
    .iBit  (iBit),
    .iReady(iReady),
    .oBin  (oBin),
    .oValid(oValid),
    .oSat  (oSat),
    .oDrop (oDrop)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] bin;
    logic       sat;
    int         at;   // expected cycle of transfer, -1 when not timed
  } exp_t;

  exp_t expQ[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT offers a result that the consumer takes.
  exp_t e;
  always @(negedge iClk) begin
    if (!iRst && oValid && iReady) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer_unexpected: got bin=%0d sat=%0d expected none", oBin, oSat);
      end else begin
        e = expQ.pop_front();
        check("xfer_bin", int'(oBin), int'(e.bin));
        check("xfer_sat", int'(oSat), int'(e.sat));
        if (e.at >= 0) check("xfer_cycle", cyc, e.at);
        $display("xfer: bin=%0d sat=%0d cycle=%0d", oBin, oSat, cyc);
      end
    end
  end

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic step(input logic en, input logic b, input logic clr, input logic rdy);
    iEn = en; iBit = b; iClr = clr; iReady = rdy;
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  // mode 0: first n bits are ones; mode 1: ones where n > sobol(i).
  function automatic logic bitFor(input int mode, input int i, input int n);
    logic [7:0] iv;
    iv = i[7:0];
    if (mode == 0) return (i < n);
    return (n > int'(rev8(iv)));
  endfunction

  // Full gapless window; optionally registers the expected result.
  task automatic window(input int mode, input int n, input logic rdy,
                        input logic push, input logic [7:0] bin, input logic sat);
    exp_t x;
    int c0;
    c0 = cyc;
    for (int i = 0; i < 256; i++) begin
      if (i == 255 && push) begin
        x.bin = bin; x.sat = sat; x.at = rdy ? c0 + 256 : -1;
        expQ.push_back(x);
      end
      step(1'b1, bitFor(mode, i, n), 1'b0, rdy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    int c0;
    int en;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    iRst = 1'b0;
    check("rst_bin", int'(oBin), 0);
    check("rst_valid", int'(oValid), 0);
    check("rst_sat", int'(oSat), 0);
    check("rst_drop", int'(oDrop), 0);

    // All ones: saturated result, one-cycle pulse.
    window(0, 256, 1'b1, 1'b1, 8'd255, 1'b1);
    check("sat_valid_now", int'(oValid), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_valid_after", int'(oValid), 0);
    check("sat_drop", int'(oDrop), 0);

    // Sobol comparator stream and all-zero stream.
    window(1, 100, 1'b1, 1'b1, 8'd100, 1'b0);
    window(0, 0, 1'b1, 1'b1, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Consumer stalls through two windows: first held, second dropped.
    window(0, 37, 1'b0, 1'b1, 8'd37, 1'b0);
    window(0, 200, 1'b0, 1'b0, 8'd0, 1'b0);
    check("hold_valid", int'(oValid), 1);
    check("hold_bin", int'(oBin), 37);
    check("hold_drop", int'(oDrop), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_consumed", int'(oValid), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_drop", int'(oDrop), 0);
    check("clr_bin_kept", int'(oBin), 37);

    // Back-to-back windows with a ready consumer: 256-cycle spacing.
    window(0, 10, 1'b1, 1'b1, 8'd10, 1'b0);
    window(0, 20, 1'b1, 1'b1, 8'd20, 1'b0);
    window(0, 30, 1'b1, 1'b1, 8'd30, 1'b0);
    check("b2b_drop", int'(oDrop), 0);

    // 64 ones with a 10-cycle enable gap inserted after 100 samples.
    c0 = cyc;
    en = 0;
    for (int i = 0; i < 266; i++) begin
      if (i >= 100 && i < 110) begin
        step(1'b0, i[0], 1'b0, 1'b1);
      end else begin
        if (en == 255) begin
          x.bin = 8'd64; x.sat = 1'b0; x.at = c0 + 266;
          expQ.push_back(x);
        end
        step(1'b1, (en < 64), 1'b0, 1'b1);
        en++;
      end
    end

    // Clear after 100 ones mid-window (bit on the clear cycle discarded).
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_valid", int'(oValid), 0);
    window(0, 50, 1'b1, 1'b1, 8'd50, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset halfway through a window, then a clean window.
    for (int i = 0; i < 128; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    iRst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    iRst = 1'b0;
    check("mrst_bin", int'(oBin), 0);
    check("mrst_valid", int'(oValid), 0);
    check("mrst_sat", int'(oSat), 0);
    check("mrst_drop", int'(oDrop), 0);
    window(0, 77, 1'b1, 1'b1, 8'd77, 1'b0);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("queue_empty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
